// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the timer_scan stopwatch:
//                controller states, special display codes, BCD digit limits
//                and the active-low digit-select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } state_t;

  // Codes understood by the downstream 7-segment decoder
  localparam logic [3:0] DIGIT_BLANK = 4'hA;
  localparam logic [3:0] DIGIT_DASH  = 4'hF;

  // BCD wrap values for each position of MM:SS
  localparam logic [3:0] ONES_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  // One-hot, active-low select for scan position idx (0 = seconds ones)
  function automatic logic [3:0] digit_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One decade of the time count. Counts 0..MAX on inc, wraps
//                to 0 and raises carry combinationally in the wrapping cycle
//                so the next digit advances on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] r_value;

  // Digit register: clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_value <= 4'd0;
    end else if (inc) begin
      r_value <= (r_value == MAX) ? 4'd0 : r_value + 4'd1;
    end
  end

  assign value = r_value;
  assign carry = inc && (r_value == MAX);

endmodule
`default_nettype wire

// File: rtl/timer_scan.sv
`default_nettype none
// ============================================================================
//  Module      : timer_scan
//  Description : MM:SS stopwatch with a 4-digit time-multiplexed scan output
//                feeding a 7-segment decoder. start_stop toggles run/pause,
//                clear returns to IDLE at 00:00, a tick at 59:59 freezes the
//                count and shows dashes until cleared.
//  Options     : define TIMER_SCAN_LZB_EN for leading-zero blanking of the
//                minute digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_scan #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] numbers,
  output logic [3:0] digit_en,
  output logic       running
);

  import timer_pkg::*;

  localparam int unsigned        TICK_W    = $clog2(TICK_DIV);
  localparam int unsigned        SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_run;
  logic              w_ovf;

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic              w_at_max;
  logic              w_inc;

  logic [3:0]        w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
  logic              w_so_carry, w_st_carry, w_mo_carry, w_unused_mt_carry;

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_scan_idx;
  logic              w_scan_adv;
  logic [1:0]        w_idx_next;
  logic [3:0]        w_code;
  logic [3:0]        r_numbers;
  logic [3:0]        r_digit_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: clear beats everything, OVF only leaves via clear
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start_stop) w_state_next = ST_RUN;
        ST_RUN: begin
          if (w_tick && w_at_max) w_state_next = ST_OVF;
          else if (start_stop)    w_state_next = ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) w_state_next = ST_RUN;
        ST_OVF:   w_state_next = ST_OVF;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    w_run = (r_state == ST_RUN);
    w_ovf = (r_state == ST_OVF);
  end

  assign running = w_run;

  // Seconds prescaler: any exit from RUN discards the partial second
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_run && (w_state_next == ST_RUN) && !w_tick) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end else begin
      r_tick_cnt <= '0;
    end
  end

  assign w_tick   = w_run && (r_tick_cnt == TICK_LAST);
  assign w_at_max = (w_sec_ones == ONES_MAX) && (w_sec_tens == SEC_TENS_MAX) &&
                    (w_min_ones == ONES_MAX) && (w_min_tens == MIN_TENS_MAX);
  // At 59:59 the final tick is swallowed so the count freezes instead of wrapping
  assign w_inc    = w_tick && !w_at_max;

  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_inc),
    .value(w_sec_ones), .carry(w_so_carry)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_so_carry),
    .value(w_sec_tens), .carry(w_st_carry)
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_st_carry),
    .value(w_min_ones), .carry(w_mo_carry)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_mo_carry),
    .value(w_min_tens), .carry(w_unused_mt_carry)
  );

  // Free-running scan slot counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
    end else begin
      r_scan_cnt <= w_scan_adv ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_adv) r_scan_idx <= r_scan_idx + 2'd1;
    end
  end

  assign w_scan_adv = (r_scan_cnt == SCAN_LAST);
  assign w_idx_next = w_scan_adv ? r_scan_idx + 2'd1 : r_scan_idx;

  // Display code for the digit about to be selected
  always_comb begin
    w_code = 4'h0;
    case (w_idx_next)
      2'd0:    w_code = w_sec_ones;
      2'd1:    w_code = w_sec_tens;
      2'd2:    w_code = w_min_ones;
      default: w_code = w_min_tens;
    endcase
`ifdef TIMER_SCAN_LZB_EN
    if ((w_idx_next == 2'd3) && (w_min_tens == 4'd0)) begin
      w_code = DIGIT_BLANK;
    end
    if ((w_idx_next == 2'd2) && (w_min_tens == 4'd0) && (w_min_ones == 4'd0)) begin
      w_code = DIGIT_BLANK;
    end
`endif
    if (w_ovf) w_code = DIGIT_DASH;
  end

  // Code and select registered together so they never skew
  always_ff @(posedge clk) begin
    if (rst) begin
      r_numbers  <= 4'h0;
      r_digit_en <= 4'b1110;
    end else begin
      r_numbers  <= w_code;
      r_digit_en <= digit_sel_n(w_idx_next);
    end
  end

  assign numbers  = r_numbers;
  assign digit_en = r_digit_en;

endmodule
`default_nettype wire

// File: tb/tb_timer_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_scan
//  Description : Self-checking bench for timer_scan with TICK_DIV=4,
//                SCAN_DIV=2. Expected values are queued when stimulus is
//                applied and popped when the DUT output is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       clr;
  logic [3:0] numbers;
  logic [3:0] digit_en;
  logic       running;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  timer_scan #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(ss),
    .clear     (clr),
    .numbers   (numbers),
    .digit_en  (digit_en),
    .running   (running)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Expected {min_tens, min_ones, sec_tens, sec_ones} display codes
  function automatic logic [15:0] exp_disp(input int mins, input int secs, input bit ovf);
    logic [3:0] mt, mo, st, so;
    if (ovf) return 16'hFFFF;
    mt = 4'(mins / 10);
    mo = 4'(mins % 10);
    st = 4'(secs / 10);
    so = 4'(secs % 10);
`ifdef TIMER_SCAN_LZB_EN
    if (mt == 4'd0) begin
      mt = 4'hA;
      if (mo == 4'd0) mo = 4'hA;
    end
`endif
    return {mt, mo, st, so};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss;
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Capture one full scan round; any non-one-hot select poisons the result
  task automatic read_disp(output logic [15:0] d);
    bit bad;
    bad = 1'b0;
    d   = 16'hxxxx;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      case (digit_en)
        4'b1110: d[3:0]   = numbers;
        4'b1101: d[7:4]   = numbers;
        4'b1011: d[11:8]  = numbers;
        4'b0111: d[15:12] = numbers;
        default: bad = 1'b1;
      endcase
    end
    if (bad) d = 16'hxxxx;
  endtask

  task automatic test_reset;
    logic [15:0] e;
    logic [15:0] d;
    logic [3:0]  seq [8];
    rst = 1'b1; ss = 1'b0; clr = 1'b0;
    wait_cyc(2);
    exp_q.push_back(16'h000E);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_checks++;
    if (digit_en !== e[3:0]) begin
      n_errors++; $display("FAIL reset_digit_en: got %b expected %b", digit_en, e[3:0]);
    end
    e = exp_q.pop_front(); n_checks++;
    if (numbers !== e[3:0]) begin
      n_errors++; $display("FAIL reset_numbers: got %h expected %h", numbers, e[3:0]);
    end
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL reset_running: got %b expected %b", running, e[0]);
    end
    rst = 1'b0;
    seq = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
    for (int i = 0; i < 8; i++) exp_q.push_back({12'h0, seq[i]});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (digit_en !== e[3:0]) begin
        n_errors++; $display("FAIL scan_seq[%0d]: got %b expected %b", i, digit_en, e[3:0]);
      end
    end
    exp_q.push_back(exp_disp(0, 0, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL idle_display: got %h expected %h", d, e);
    end
  endtask

  task automatic test_count;
    logic [15:0] e;
    logic [15:0] d;
    pulse_ss;
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL run_running: got %b expected %b", running, e[0]);
    end
    wait_cyc(40);
    pulse_ss;
    exp_q.push_back(exp_disp(0, 10, 0));
    exp_q.push_back(16'h0000);
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL count_00_10: got %h expected %h", d, e);
    end
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL pause_running: got %b expected %b", running, e[0]);
    end
    pulse_clr;
  endtask

  task automatic test_pause_resume;
    logic [15:0] e;
    logic [15:0] d;
    pulse_ss;
    wait_cyc(36);
    pulse_ss;
    wait_cyc(20);
    exp_q.push_back(exp_disp(0, 9, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL pause_hold_00_09: got %h expected %h", d, e);
    end
    // Three cycles of RUN are not enough for a tick
    pulse_ss;
    wait_cyc(2);
    pulse_ss;
    exp_q.push_back(exp_disp(0, 9, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL resume_3cyc: got %h expected %h", d, e);
    end
    // Four cycles of RUN give exactly one tick
    pulse_ss;
    wait_cyc(3);
    pulse_ss;
    exp_q.push_back(exp_disp(0, 10, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL resume_4cyc: got %h expected %h", d, e);
    end
    pulse_clr;
  endtask

  task automatic test_overflow;
    logic [15:0] e;
    logic [15:0] d;
    pulse_ss;
    wait_cyc(4 * 3599);
    pulse_ss;
    exp_q.push_back(exp_disp(59, 59, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL count_59_59: got %h expected %h", d, e);
    end
    pulse_ss;
    wait_cyc(3);
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL pre_ovf_running: got %b expected %b", running, e[0]);
    end
    wait_cyc(1);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL ovf_running: got %b expected %b", running, e[0]);
    end
    exp_q.push_back(exp_disp(59, 59, 1));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL ovf_dashes: got %h expected %h", d, e);
    end
    pulse_ss;
    exp_q.push_back(16'h0000);
    exp_q.push_back(exp_disp(59, 59, 1));
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL ovf_ignore_ss_running: got %b expected %b", running, e[0]);
    end
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL ovf_ignore_ss_disp: got %h expected %h", d, e);
    end
    pulse_clr;
    exp_q.push_back(16'h0000);
    exp_q.push_back(exp_disp(0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL ovf_clear_running: got %b expected %b", running, e[0]);
    end
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL ovf_clear_disp: got %h expected %h", d, e);
    end
  endtask

  task automatic test_clear_priority;
    logic [15:0] e;
    logic [15:0] d;
    pulse_ss;
    wait_cyc(10);
    clr = 1'b1; ss = 1'b1;
    @(negedge clk);
    clr = 1'b0; ss = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(exp_disp(0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (running !== e[0]) begin
      n_errors++; $display("FAIL clr_ss_running: got %b expected %b", running, e[0]);
    end
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL clr_ss_disp: got %h expected %h", d, e);
    end
    // From IDLE a fresh start counts its first second after TICK_DIV cycles
    pulse_ss;
    wait_cyc(4);
    pulse_ss;
    exp_q.push_back(exp_disp(0, 1, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL restart_first_tick: got %h expected %h", d, e);
    end
    pulse_clr;
  endtask

  task automatic test_blanking;
    logic [15:0] e;
    logic [15:0] d;
    pulse_ss;
    wait_cyc(28);
    pulse_ss;
    exp_q.push_back(exp_disp(0, 7, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL disp_00_07: got %h expected %h", d, e);
    end
    pulse_ss;
    wait_cyc(4 * 593);
    pulse_ss;
    exp_q.push_back(exp_disp(10, 0, 0));
    read_disp(d);
    e = exp_q.pop_front(); n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL disp_10_00: got %h expected %h", d, e);
    end
    pulse_clr;
  endtask

  initial begin
    test_reset;
    test_count;
    test_pause_resume;
    test_overflow;
    test_clear_priority;
    test_blanking;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
